// File: rtl/pid_channel_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : pid_channel_scheduler_if
// Brief    : Valid/ready sample stream from the channel scheduler to the PID core.
// Revision : 1.0 - initial release
// ============================================================================
interface pid_channel_scheduler_if #(
   parameter int W_DATA = 18,
   parameter int N_CHAN = 8
);
   localparam int W_CH = $clog2(N_CHAN);

   logic              pid_valid_out;
   logic              pid_ready_in;
   logic [W_CH-1:0]   pid_chan_out;
   logic [W_DATA-1:0] pid_data_out;

   modport master (
      output pid_valid_out,
      output pid_chan_out,
      output pid_data_out,
      input  pid_ready_in
   );

   modport slave (
      input  pid_valid_out,
      input  pid_chan_out,
      input  pid_data_out,
      output pid_ready_in
   );
endinterface
`default_nettype wire

// File: rtl/pid_channel_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : pid_channel_scheduler
// Brief    : Buffers one ADC sample per channel and issues them round-robin to
//            the shared PID core; optional overrun counter via PID_SCHED_OVF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pid_channel_scheduler #(
   parameter int W_DATA = 18,
   parameter int N_CHAN = 8,
   parameter int W_CNT  = 8
) (
   input  logic                    clk_in,
   input  logic                    reset_in,
   input  logic [N_CHAN-1:0]       chan_en_in,
   input  logic                    update_in,
   input  logic [N_CHAN-1:0]       data_valid_in,
   input  logic [W_DATA-1:0]       data_a_in,
   input  logic [W_DATA-1:0]       data_b_in,
   pid_channel_scheduler_if.master pid_if,
   input  logic                    ovf_clr_in,
   output logic [N_CHAN-1:0]       ovf_out,
   output logic [W_CNT-1:0]        ovf_cnt_out
);
   localparam int W_CH = $clog2(N_CHAN);
   localparam int WS   = W_CH + 1;
   localparam int HALF = N_CHAN / 2;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_HOLD = 1'b1;

   logic [0:0]        state_q, state_d;
   logic [N_CHAN-1:0] chan_en_q, chan_en_d;
   logic [N_CHAN-1:0] pend_q, pend_d;
   logic [N_CHAN-1:0] ovf_q, ovf_d;
   logic [W_CH-1:0]   last_grant_q, last_grant_d;
   logic [W_CH-1:0]   out_chan_q, out_chan_d;
   logic [W_DATA-1:0] out_data_q, out_data_d;
   logic [W_DATA-1:0] sample_q [N_CHAN];
   logic [W_DATA-1:0] sample_d [N_CHAN];

   logic              slot_free;
   logic              grant_vld;
   logic [W_CH-1:0]   grant_idx;
   logic [WS-1:0]     cand;
   logic [N_CHAN-1:0] grant_oh;
   logic [N_CHAN-1:0] capture;
   logic [N_CHAN-1:0] overrun;

   assign slot_free = (state_q == ST_IDLE) || pid_if.pid_ready_in;

   // Scan from the farthest candidate down so the nearest pending channel
   // after last_grant is the one left standing.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      cand      = '0;
      if (slot_free) begin
         for (int k = N_CHAN; k >= 1; k--) begin
            cand = {1'b0, last_grant_q} + WS'(k);
            if (cand >= WS'(N_CHAN)) begin
               cand = cand - WS'(N_CHAN);
            end
            if (pend_q[cand[W_CH-1:0]]) begin
               grant_vld = 1'b1;
               grant_idx = cand[W_CH-1:0];
            end
         end
      end
   end

   assign grant_oh = grant_vld ? ({{(N_CHAN-1){1'b0}}, 1'b1} << grant_idx) : '0;

   // A capture into the channel being granted this cycle is a refill, not an overrun.
   always_comb begin
      capture = data_valid_in & chan_en_q;
      overrun = capture & pend_q & ~grant_oh;
      for (int i = 0; i < N_CHAN; i++) begin
         if (capture[i]) begin
            sample_d[i] = (i < HALF) ? data_a_in : data_b_in;
         end else begin
            sample_d[i] = sample_q[i];
         end
      end
   end

   always_comb begin
      chan_en_d = chan_en_q;
      pend_d    = (pend_q & ~grant_oh) | capture;
      if (update_in) begin
         chan_en_d = chan_en_in;
         pend_d    = pend_d & chan_en_in;
      end
      ovf_d = (ovf_clr_in ? '0 : ovf_q) | overrun;
   end

   always_comb begin
      state_d      = state_q;
      out_chan_d   = out_chan_q;
      out_data_d   = out_data_q;
      last_grant_d = last_grant_q;
      if (grant_vld) begin
         state_d      = ST_HOLD;
         out_chan_d   = grant_idx;
         out_data_d   = sample_q[grant_idx];
         last_grant_d = grant_idx;
      end else if (slot_free) begin
         state_d = ST_IDLE;
      end
   end

   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         state_q      <= ST_IDLE;
         chan_en_q    <= '1;
         pend_q       <= '0;
         ovf_q        <= '0;
         last_grant_q <= W_CH'(N_CHAN - 1);
         out_chan_q   <= '0;
         out_data_q   <= '0;
         for (int i = 0; i < N_CHAN; i++) begin
            sample_q[i] <= '0;
         end
      end else begin
         state_q      <= state_d;
         chan_en_q    <= chan_en_d;
         pend_q       <= pend_d;
         ovf_q        <= ovf_d;
         last_grant_q <= last_grant_d;
         out_chan_q   <= out_chan_d;
         out_data_q   <= out_data_d;
         for (int i = 0; i < N_CHAN; i++) begin
            sample_q[i] <= sample_d[i];
         end
      end
   end

   assign pid_if.pid_valid_out = (state_q == ST_HOLD);
   assign pid_if.pid_chan_out  = out_chan_q;
   assign pid_if.pid_data_out  = out_data_q;
   assign ovf_out              = ovf_q;

`ifdef PID_SCHED_OVF_CNT_EN
   localparam int W_POP = $clog2(N_CHAN + 1);
   localparam int W_SUM = ((W_CNT > W_POP) ? W_CNT : W_POP) + 1;
   localparam logic [W_SUM-1:0] CNT_MAX = {{(W_SUM-W_CNT){1'b0}}, {W_CNT{1'b1}}};

   logic [W_CNT-1:0] ovf_cnt_q, ovf_cnt_d;
   logic [W_POP-1:0] ovr_pop;
   logic [W_SUM-1:0] cnt_sum;

   // Overruns landing on the clear cycle still count.
   always_comb begin
      ovr_pop = '0;
      for (int i = 0; i < N_CHAN; i++) begin
         ovr_pop = ovr_pop + W_POP'(overrun[i]);
      end
      cnt_sum   = (ovf_clr_in ? '0 : W_SUM'(ovf_cnt_q)) + W_SUM'(ovr_pop);
      ovf_cnt_d = (cnt_sum > CNT_MAX) ? {W_CNT{1'b1}} : cnt_sum[W_CNT-1:0];
   end

   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         ovf_cnt_q <= '0;
      end else begin
         ovf_cnt_q <= ovf_cnt_d;
      end
   end

   assign ovf_cnt_out = ovf_cnt_q;
`else
   assign ovf_cnt_out = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pid_channel_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_pid_channel_scheduler
// Brief    : Directed bench with a cycle-level scheduler model and literal checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pid_channel_scheduler;
   localparam int NC      = 8;
   localparam int CNT_MAX = 3;

   logic        clk_in = 1'b0;
   logic        reset_in = 1'b1;
   logic [7:0]  chan_en_in = 8'hFF;
   logic        update_in = 1'b0;
   logic [7:0]  data_valid_in = 8'h00;
   logic [17:0] data_a_in = '0;
   logic [17:0] data_b_in = '0;
   logic        ovf_clr_in = 1'b0;
   logic [7:0]  ovf_out;
   logic [1:0]  ovf_cnt_out;

   pid_channel_scheduler_if #(.W_DATA(18), .N_CHAN(NC)) pif ();

   pid_channel_scheduler #(.W_DATA(18), .N_CHAN(NC), .W_CNT(2)) dut (
      .clk_in        (clk_in),
      .reset_in      (reset_in),
      .chan_en_in    (chan_en_in),
      .update_in     (update_in),
      .data_valid_in (data_valid_in),
      .data_a_in     (data_a_in),
      .data_b_in     (data_b_in),
      .pid_if        (pif),
      .ovf_clr_in    (ovf_clr_in),
      .ovf_out       (ovf_out),
      .ovf_cnt_out   (ovf_cnt_out)
   );

   always #5 clk_in = ~clk_in;

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: one buffered sample per channel, a single output slot,
   // round-robin pick starting after the previous winner.
   bit [7:0]    m_en, m_pend, m_ovf;
   logic [17:0] m_sample [NC];
   bit          m_valid;
   int          m_chan, m_last, m_cnt, m_grant, m_pop;
   logic [17:0] m_data;

   always @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         m_en = 8'hFF; m_pend = 0; m_ovf = 0; m_valid = 0;
         m_chan = 0; m_data = 0; m_last = NC - 1; m_cnt = 0;
         for (int i = 0; i < NC; i++) m_sample[i] = 0;
      end else begin
         m_grant = -1;
         if (!m_valid || pif.pid_ready_in) begin
            for (int k = 1; k <= NC; k++)
               if (m_grant < 0 && m_pend[(m_last + k) % NC]) m_grant = (m_last + k) % NC;
            if (m_grant >= 0) begin
               m_valid = 1; m_chan = m_grant; m_data = m_sample[m_grant];
               m_last = m_grant; m_pend[m_grant] = 0;
            end else begin
               m_valid = 0;
            end
         end
         if (ovf_clr_in) begin m_ovf = 0; m_cnt = 0; end
         m_pop = 0;
         for (int i = 0; i < NC; i++) begin
            if (data_valid_in[i] && m_en[i]) begin
               if (m_pend[i]) begin m_ovf[i] = 1; m_pop++; end
               m_pend[i] = 1;
               m_sample[i] = (i < NC / 2) ? data_a_in : data_b_in;
            end
         end
`ifdef PID_SCHED_OVF_CNT_EN
         m_cnt = (m_cnt + m_pop > CNT_MAX) ? CNT_MAX : m_cnt + m_pop;
`endif
         if (update_in) begin m_en = chan_en_in; m_pend &= chan_en_in; end
      end
      #1;
      check("valid", 32'(pif.pid_valid_out), 32'(m_valid));
      check("chan", 32'(pif.pid_chan_out), 32'(m_chan));
      check("data", 32'(pif.pid_data_out), 32'(m_data));
      check("ovf", 32'(ovf_out), 32'(m_ovf));
      check("ovf_cnt", 32'(ovf_cnt_out), 32'(m_cnt));
   end

   int          log_chan [$];
   logic [17:0] log_data [$];

   always @(posedge clk_in) begin
      if (!reset_in && pif.pid_valid_out && pif.pid_ready_in) begin
         log_chan.push_back(int'(pif.pid_chan_out));
         log_data.push_back(pif.pid_data_out);
      end
   end

   task automatic check_log(input int idx, input int chan, input logic [17:0] data);
      if (idx >= log_chan.size()) begin
         check($sformatf("log%0d_present", idx), 32'(log_chan.size()), 32'(idx + 1));
      end else begin
         check($sformatf("log%0d_chan", idx), 32'(log_chan[idx]), 32'(chan));
         check($sformatf("log%0d_data", idx), 32'(log_data[idx]), 32'(data));
      end
   endtask

   task automatic drive(input logic [7:0] v, input logic [17:0] a, input logic [17:0] b);
      @(negedge clk_in);
      data_valid_in = v; data_a_in = a; data_b_in = b;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(8'h00, 18'h0, 18'h0);
   endtask

   task automatic do_reset(input logic ready);
      @(negedge clk_in);
      reset_in = 1'b1; data_valid_in = 0; update_in = 0; ovf_clr_in = 0;
      chan_en_in = 8'hFF; pif.pid_ready_in = ready;
      @(negedge clk_in);
      reset_in = 1'b0;
      log_chan.delete(); log_data.delete();
   endtask

   task automatic load_all();
      drive(8'h11, 18'h00100, 18'h00200);
      drive(8'h22, 18'h00101, 18'h00201);
      drive(8'h44, 18'h00102, 18'h00202);
      drive(8'h88, 18'h00103, 18'h00203);
   endtask

   initial begin
      pif.pid_ready_in = 1'b1;
      repeat (2) @(negedge clk_in);
      check("rst_valid", 32'(pif.pid_valid_out), 32'h0);
      check("rst_chan", 32'(pif.pid_chan_out), 32'h0);
      check("rst_data", 32'(pif.pid_data_out), 32'h0);
      check("rst_ovf", 32'(ovf_out), 32'h0);
      check("rst_cnt", 32'(ovf_cnt_out), 32'h0);

      // Basic pair: latency two cycles, channel 0 then channel 4, then idle.
      do_reset(1'b1);
      drive(8'h11, 18'h00123, 18'h3FFFF);
      drive(8'h00, 18'h0, 18'h0);
      @(posedge clk_in); #2;
      check("s1_valid0", 32'(pif.pid_valid_out), 32'h1);
      check("s1_chan0", 32'(pif.pid_chan_out), 32'h0);
      check("s1_data0", 32'(pif.pid_data_out), 32'h00123);
      @(posedge clk_in); #2;
      check("s1_chan4", 32'(pif.pid_chan_out), 32'h4);
      check("s1_data4", 32'(pif.pid_data_out), 32'h3FFFF);
      @(posedge clk_in); #2;
      check("s1_idle", 32'(pif.pid_valid_out), 32'h0);

      // All eight pending, then drained in order, then a new round.
      do_reset(1'b0);
      load_all();
      drive(8'h00, 18'h0, 18'h0);
      pif.pid_ready_in = 1'b1;
      idle(10);
      for (int i = 0; i < 4; i++) begin
         check_log(i, i, 18'h00100 + 18'(i));
         check_log(i + 4, i + 4, 18'h00200 + 18'(i));
      end
      drive(8'h11, 18'h00055, 18'h00066);
      idle(4);
      check_log(8, 0, 18'h00055);
      check_log(9, 4, 18'h00066);

      // Back-pressure hold with a channel 3 overrun; newer value goes out.
      do_reset(1'b0);
      drive(8'h01, 18'h00010, 18'h0);
      drive(8'h08, 18'h00030, 18'h0);
      drive(8'h08, 18'h00033, 18'h0);
      idle(3);
      check("s3_held_valid", 32'(pif.pid_valid_out), 32'h1);
      check("s3_held_chan", 32'(pif.pid_chan_out), 32'h0);
      check("s3_ovf3", 32'(ovf_out), 32'h08);
      pif.pid_ready_in = 1'b1;
      idle(4);
      check_log(0, 0, 18'h00010);
      check_log(1, 3, 18'h00033);
      check("s3_cnt", 32'(log_chan.size()), 32'd2);

      // Disable channels 4-7 while they are pending.
      do_reset(1'b0);
      load_all();
      @(negedge clk_in);
      data_valid_in = 0; update_in = 1'b1; chan_en_in = 8'h0F;
      @(negedge clk_in);
      update_in = 1'b0;
      drive(8'h40, 18'h0, 18'h002AA);
      drive(8'h00, 18'h0, 18'h0);
      pif.pid_ready_in = 1'b1;
      idle(10);
      for (int i = 0; i < 4; i++) check_log(i, i, 18'h00100 + 18'(i));
      check("s4_count", 32'(log_chan.size()), 32'd4);

      // Grant and capture on channel 2 in the same cycle.
      do_reset(1'b1);
      drive(8'h04, 18'h00021, 18'h0);
      drive(8'h04, 18'h00022, 18'h0);
      idle(4);
      check_log(0, 2, 18'h00021);
      check_log(1, 2, 18'h00022);
      check("s5_ovf", 32'(ovf_out), 32'h0);

      // Five overruns on channel 1 saturate a 2-bit counter; then clear.
      do_reset(1'b0);
      drive(8'h01, 18'h00010, 18'h0);
      for (int i = 0; i < 6; i++) drive(8'h02, 18'h00040 + 18'(i), 18'h0);
      idle(1);
      check("s6_ovf", 32'(ovf_out), 32'h02);
`ifdef PID_SCHED_OVF_CNT_EN
      check("s6_cnt_sat", 32'(ovf_cnt_out), 32'd3);
`else
      check("s6_cnt_off", 32'(ovf_cnt_out), 32'd0);
`endif
      @(negedge clk_in); ovf_clr_in = 1'b1;
      @(negedge clk_in); ovf_clr_in = 1'b0;
      check("s6_ovf_clr", 32'(ovf_out), 32'h0);
      check("s6_cnt_clr", 32'(ovf_cnt_out), 32'd0);
      pif.pid_ready_in = 1'b1;
      idle(4);
      check_log(1, 1, 18'h00045);

      // Reset mid-operation discards the pending work.
      do_reset(1'b0);
      drive(8'h11, 18'h00077, 18'h00088);
      drive(8'h22, 18'h00079, 18'h00089);
      do_reset(1'b1);
      idle(4);
      check("s7_valid", 32'(pif.pid_valid_out), 32'h0);
      check("s7_log", 32'(log_chan.size()), 32'd0);

      idle(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish by %0t", $time);
      $fatal(1);
   end
endmodule
`default_nettype wire

// File: doc/pid_channel_scheduler.md
# pid_channel_scheduler

Sits between the AD7608 controller and the shared PID core. Captures the per-channel samples from the ADC's two serial-port data buses (one-hot valid), buffers one sample per channel, and issues them one at a time to the single-issue PID pipeline over a valid/ready handshake using round-robin arbitration. Flags per-channel overruns when a new sample arrives before the previous one was issued.

## Interface
- W_DATA, 18, sample width (matches ADC data width)
- N_CHAN, 8, channel count; must be even, ≥2
- W_CNT, 8, width of overrun counter (see Configuration)

- clk_in  input  1  system clock (ADC serial clock domain)
- reset_in  input  1  reset, asynchronous, active-high
- chan_en_in  input  N_CHAN  channel enable mask from frontpanel
- update_in  input  1  single-cycle pulse; latches chan_en_in
- data_valid_in  input  N_CHAN  one-hot-per-half sample valid from ADC controller
- data_a_in  input  W_DATA  signed sample for channels 0..N_CHAN/2-1
- data_b_in  input  W_DATA  signed sample for channels N_CHAN/2..N_CHAN-1
- pid_ready_in  input  1  PID core accepts sample this cycle
- pid_valid_out  output  1  sample on pid_data_out valid
- pid_chan_out  output  $clog2(N_CHAN)  channel index of issued sample
- pid_data_out  output  W_DATA  signed sample to PID core
- ovf_clr_in  input  1  pulse; clears ovf_out and overrun counter
- ovf_out  output  N_CHAN  sticky per-channel overrun flags
- ovf_cnt_out  output  W_CNT  saturating total overrun count

## Operation
- Enable register chan_en: resets to all ones; loads chan_en_in on update_in. On load, pend[i] cleared for every channel becoming disabled.
- Capture: for each i with data_valid_in[i] & chan_en[i]: sample[i] <= (i < N_CHAN/2) ? data_a_in : data_b_in; pend[i] <= 1. Bits i and i+N_CHAN/2 arrive together; both captured same cycle.
- Overrun: capture into channel with pend[i]=1 not granted that cycle -> overwrite sample[i] with new value, set ovf_out[i].
- Arbiter states: IDLE (pid_valid_out=0) and HOLD (pid_valid_out=1).
  - Output slot free when IDLE, or HOLD with pid_ready_in=1.
  - Slot free and any pend: grant first pending channel searching upward from last_grant+1 (mod N_CHAN); load pid_data_out/pid_chan_out from sample/index, clear pend[grant], last_grant <= grant, go/stay HOLD.
  - Slot free, no pend: IDLE.
  - HOLD with pid_ready_in=0: outputs held stable, no grant.
- Grant and capture on same channel same cycle: output takes old sample[i]; new sample stored, pend[i] stays 1; no overrun.
- Disabled channel currently in output slot still completes its handshake.
- ovf_clr_in clears ovf_out (and counter); a simultaneous overrun wins (flag set).

## Timing
- Reset: pid_valid_out=0, pid_chan_out=0, pid_data_out=0, ovf_out=0, ovf_cnt_out=0, pend=0, sample=0, chan_en=all ones, last_grant=N_CHAN-1 (channel 0 first).
- Latency: data_valid_in at cycle t -> pend at t+1 -> pid_valid_out high at t+2 earliest.
- Throughput: one sample per cycle while pid_ready_in=1.
- Handshake: transfer when pid_valid_out & pid_ready_in at clock edge; valid never drops without transfer except on reset.
- Reset mid-operation: all state returns to reset values immediately; pending samples discarded.

## Configuration
- PID_SCHED_OVF_CNT_EN defined: ovf_cnt_out increments by the number of overruns each cycle (popcount, up to 2), saturating at 2^W_CNT-1; cleared by ovf_clr_in.
- Not defined: counter not built; ovf_cnt_out tied to 0. ovf_out unaffected.

## Test plan
- Reset, pid_ready_in=1, data_valid_in=8'h01/8'h10 pulse with data_a=18'h00123, data_b=18'h3FFFF -> cycle t+2 chan 0 data 18'h00123, t+3 chan 4 data 18'h3FFFF, then IDLE.
- Four valid pairs (all 8 channels pending), pid_ready_in=1 -> issued 0..7 in order on consecutive cycles; next round starts after last grant.
- pid_ready_in=0 while HOLD for 5 cycles -> pid_valid_out, chan, data held constant; ovf_out[3] set when channel 3 receives a second sample meanwhile, issued value is the newer one.
- update_in with chan_en_in=8'h0F while channels 4-7 pending -> pend[4:7] cleared, only channels 0-3 issued; later valid on channel 6 ignored.
- Capture on channel 2 same cycle it is granted -> old value issued, new value issued next round, ovf_out[2]=0.
- With PID_SCHED_OVF_CNT_EN, W_CNT=2: 5 overruns -> ovf_cnt_out=3; ovf_clr_in -> 0. Without macro -> ovf_cnt_out stays 0.
